// File: rtl/mcpu_core_pkg.sv
// Shared types and constants for the 4-lane core issue path.
// Holds the decoded-bundle layout and the issue-gate state encoding.
package mcpu_core_pkg;

    localparam int LANES       = 4;
    localparam int REG_W       = 5;
    localparam int PRED_W      = 2;
    localparam int NUM_REGS    = 32;
    localparam int NUM_PREDS   = 3;
    localparam logic [PRED_W-1:0] PRED_ALWAYS = 2'd3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        READY = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic [2*LANES*REG_W-1:0] rs_num;
        logic [2*LANES-1:0]       rs_use;
        logic [LANES*PRED_W-1:0]  pred_num;
        logic [LANES*REG_W-1:0]   rd_num;
        logic [LANES-1:0]         rd_we;
        logic [LANES-1:0]         pred_we;
    } bundle_t;

endpackage

// File: rtl/mcpu_core_issue_gate_if.sv
// Decode / scoreboard / PC-side signal bundle of the issue gate.
// The gate connects through the slave modport; its environment uses master.
interface mcpu_core_issue_gate_if #(
    parameter int STALL_W = 16
);
    logic               flush;
    logic               d2ig_valid;
    logic               ig2d_ready;
    logic [39:0]        d2ig_rs_num;
    logic [7:0]         d2ig_rs_use;
    logic [7:0]         d2ig_pred_num;
    logic [19:0]        d2ig_rd_num;
    logic [3:0]         d2ig_rd_we;
    logic [3:0]         d2ig_pred_we;
    logic [31:0]        sb2d_reg_scoreboard;
    logic [2:0]         sb2d_pred_scoreboard;
    logic               pc2d_ready;
    logic               d2pc_valid;
    logic               d2pc_progress;
    logic [4:0]         d2pc_out_rd_num0;
    logic [4:0]         d2pc_out_rd_num1;
    logic [4:0]         d2pc_out_rd_num2;
    logic [4:0]         d2pc_out_rd_num3;
    logic               d2pc_out_rd_we0;
    logic               d2pc_out_rd_we1;
    logic               d2pc_out_rd_we2;
    logic               d2pc_out_rd_we3;
    logic               d2pc_out_pred_we0;
    logic               d2pc_out_pred_we1;
    logic               d2pc_out_pred_we2;
    logic               d2pc_out_pred_we3;
    logic [STALL_W-1:0] ig_stall_cycles;

    modport master (
        output flush, d2ig_valid, d2ig_rs_num, d2ig_rs_use, d2ig_pred_num,
               d2ig_rd_num, d2ig_rd_we, d2ig_pred_we,
               sb2d_reg_scoreboard, sb2d_pred_scoreboard, pc2d_ready,
        input  ig2d_ready, d2pc_valid, d2pc_progress,
               d2pc_out_rd_num0, d2pc_out_rd_num1, d2pc_out_rd_num2, d2pc_out_rd_num3,
               d2pc_out_rd_we0, d2pc_out_rd_we1, d2pc_out_rd_we2, d2pc_out_rd_we3,
               d2pc_out_pred_we0, d2pc_out_pred_we1, d2pc_out_pred_we2, d2pc_out_pred_we3,
               ig_stall_cycles
    );

    modport slave (
        input  flush, d2ig_valid, d2ig_rs_num, d2ig_rs_use, d2ig_pred_num,
               d2ig_rd_num, d2ig_rd_we, d2ig_pred_we,
               sb2d_reg_scoreboard, sb2d_pred_scoreboard, pc2d_ready,
        output ig2d_ready, d2pc_valid, d2pc_progress,
               d2pc_out_rd_num0, d2pc_out_rd_num1, d2pc_out_rd_num2, d2pc_out_rd_num3,
               d2pc_out_rd_we0, d2pc_out_rd_we1, d2pc_out_rd_we2, d2pc_out_rd_we3,
               d2pc_out_pred_we0, d2pc_out_pred_we1, d2pc_out_pred_we2, d2pc_out_pred_we3,
               ig_stall_cycles
    );

endinterface

// File: rtl/mcpu_core_issue_hazard.sv
// Combinational RAW / WAW hazard check of one held bundle against the
// register and predicate scoreboards.
module mcpu_core_issue_hazard
    import mcpu_core_pkg::*;
(
    input  bundle_t               bundle_i,
    input  logic [NUM_REGS-1:0]   reg_sb_i,
    input  logic [NUM_PREDS-1:0]  pred_sb_i,
    output logic                  hazard_o
);

    logic [3:0] pred_busy;

    // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        // Index 3 is the always-true predicate and is padded in as never busy.
        pred_busy = {1'b0, pred_sb_i};
        hazard_o  = 1'b0;
        for (int s = 0; s < 2*LANES; s++) begin
            if (bundle_i.rs_use[s] && reg_sb_i[bundle_i.rs_num[s*REG_W +: REG_W]])
                hazard_o = 1'b1;
        end
        for (int l = 0; l < LANES; l++) begin
            if (bundle_i.pred_num[l*PRED_W +: PRED_W] != PRED_ALWAYS &&
                pred_busy[bundle_i.pred_num[l*PRED_W +: PRED_W]])
                hazard_o = 1'b1;
            if (bundle_i.rd_we[l] && reg_sb_i[bundle_i.rd_num[l*REG_W +: REG_W]])
                hazard_o = 1'b1;
            if (bundle_i.pred_we[l] && pred_busy[bundle_i.rd_num[l*REG_W +: PRED_W]])
                hazard_o = 1'b1;
        end
    end

endmodule

// File: rtl/mcpu_core_issue_gate.sv
// Decode-side issue gate: holds one bundle, stalls it on scoreboard hazards
// and issues it downstream. Optional stall counter: MCPU_ISSUE_STALL_CNT_EN.
module mcpu_core_issue_gate
    import mcpu_core_pkg::*;
#(
    parameter int STALL_W = 16
) (
    input logic                   clkrst_core_clk,
    input logic                   clkrst_core_rst,
    mcpu_core_issue_gate_if.slave ig
);

    issue_state_t state_q, state_d, cur_state;
    bundle_t      bundle_q, bundle_d, in_bundle;
    logic         held, hazard, valid, progress, ready, load;

    assign in_bundle = '{rs_num:   ig.d2ig_rs_num,
                         rs_use:   ig.d2ig_rs_use,
                         pred_num: ig.d2ig_pred_num,
                         rd_num:   ig.d2ig_rd_num,
                         rd_we:    ig.d2ig_rd_we,
                         pred_we:  ig.d2ig_pred_we};

    mcpu_core_issue_hazard u_hazard (
        .bundle_i (bundle_q),
        .reg_sb_i (ig.sb2d_reg_scoreboard),
        .pred_sb_i(ig.sb2d_pred_scoreboard),
        .hazard_o (hazard)
    );

    always_comb begin
        held      = (state_q != EMPTY);
        // HOLD vs READY follows the live scoreboard, not the value captured at load.
        cur_state = !held ? EMPTY : (hazard ? HOLD : READY);
        valid     = held & ~hazard & ~ig.flush;
        progress  = valid & ig.pc2d_ready;
        ready     = ~held | progress;
        load      = ig.d2ig_valid & ready & ~ig.flush;

        state_d  = cur_state;
        bundle_d = bundle_q;
        if (ig.flush) begin
            state_d  = EMPTY;
            bundle_d = '0;
        end else if (load) begin
            state_d  = READY;
            bundle_d = in_bundle;
        end else if (progress) begin
            state_d  = EMPTY;
            bundle_d = '0;
        end
    end

    // NOTE: non-blocking assignments make every flop sample the same pre-edge values.
    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            state_q  <= EMPTY;
            bundle_q <= '0;
        end else begin
            state_q  <= state_d;
            bundle_q <= bundle_d;
        end
    end

    assign ig.ig2d_ready    = ready;
    assign ig.d2pc_valid    = valid;
    assign ig.d2pc_progress = progress;

    // Dropped bundles are zeroed, so these read 0 whenever nothing is held.
    assign ig.d2pc_out_rd_num0  = bundle_q.rd_num[0*REG_W +: REG_W];
    assign ig.d2pc_out_rd_num1  = bundle_q.rd_num[1*REG_W +: REG_W];
    assign ig.d2pc_out_rd_num2  = bundle_q.rd_num[2*REG_W +: REG_W];
    assign ig.d2pc_out_rd_num3  = bundle_q.rd_num[3*REG_W +: REG_W];
    assign ig.d2pc_out_rd_we0   = bundle_q.rd_we[0];
    assign ig.d2pc_out_rd_we1   = bundle_q.rd_we[1];
    assign ig.d2pc_out_rd_we2   = bundle_q.rd_we[2];
    assign ig.d2pc_out_rd_we3   = bundle_q.rd_we[3];
    assign ig.d2pc_out_pred_we0 = bundle_q.pred_we[0];
    assign ig.d2pc_out_pred_we1 = bundle_q.pred_we[1];
    assign ig.d2pc_out_pred_we2 = bundle_q.pred_we[2];
    assign ig.d2pc_out_pred_we3 = bundle_q.pred_we[3];

`ifdef MCPU_ISSUE_STALL_CNT_EN
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cur_state == HOLD && stall_cnt_q != {STALL_W{1'b1}})
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end

    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) stall_cnt_q <= '0;
        else                 stall_cnt_q <= stall_cnt_d;
    end

    assign ig.ig_stall_cycles = stall_cnt_q;
`else
    assign ig.ig_stall_cycles = {STALL_W{1'b0}};
`endif

endmodule

// File: tb/tb_mcpu_core_issue_gate.sv
// Self-checking bench for mcpu_core_issue_gate: directed vector table,
// hand-written multi-cycle sequences and random stimulus against a reference model.
module tb_mcpu_core_issue_gate;

    typedef struct packed {
        logic        valid;
        logic [39:0] rs;
        logic [7:0]  uses;
        logic [7:0]  pr;
        logic [19:0] rd;
        logic [3:0]  rwe;
        logic [3:0]  pwe;
        logic [31:0] rsb;
        logic [2:0]  psb;
        logic        pcr;
        logic        fl;
    } in_t;

    typedef struct packed {
        in_t  st;
        logic ev;
        logic ep;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    bit   m_held;
    in_t  m_b;
    int   m_stall;

    logic       obs_valid, obs_prog, obs_ready, obs_we0;
    logic [4:0] obs_rd0;

    mcpu_core_issue_gate_if #(.STALL_W(16)) ig ();

    mcpu_core_issue_gate #(.STALL_W(16)) dut (
        .clkrst_core_clk(clk),
        .clkrst_core_rst(rst),
        .ig             (ig.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic in_t blank();
        in_t b;
        b    = '0;
        b.pr = 8'hFF;
        return b;
    endfunction

    // Spec rules applied with shifts/masks over the flat fields.
    function automatic bit model_hazard(input in_t b, input logic [31:0] rsb, input logic [2:0] psb);
        bit h;
        int r, p, d;
        h = 0;
        for (int i = 0; i < 8; i++) begin
            r = int'((b.rs >> (5*i)) & 40'd31);
            if (b.uses[i] && rsb[r]) h = 1;
        end
        for (int l = 0; l < 4; l++) begin
            p = int'((b.pr >> (2*l)) & 8'd3);
            d = int'((b.rd >> (5*l)) & 20'd31);
            if (p < 3 && psb[p]) h = 1;
            if (b.rwe[l] && rsb[d]) h = 1;
            if (b.pwe[l] && (d % 4) < 3 && psb[d % 4]) h = 1;
        end
        return h;
    endfunction

    function automatic logic [27:0] model_outs(input in_t b);
        return {b.rd, b.rwe, b.pwe};
    endfunction

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input in_t s);
        bit          haz, e_valid, e_prog, e_ready;
        logic [63:0] e_stall;
        ig.flush                = s.fl;
        ig.d2ig_valid           = s.valid;
        ig.d2ig_rs_num          = s.rs;
        ig.d2ig_rs_use          = s.uses;
        ig.d2ig_pred_num        = s.pr;
        ig.d2ig_rd_num          = s.rd;
        ig.d2ig_rd_we           = s.rwe;
        ig.d2ig_pred_we         = s.pwe;
        ig.sb2d_reg_scoreboard  = s.rsb;
        ig.sb2d_pred_scoreboard = s.psb;
        ig.pc2d_ready           = s.pcr;
        #2;
        haz     = m_held && model_hazard(m_b, s.rsb, s.psb);
        e_valid = m_held && !haz && !s.fl;
        e_prog  = e_valid && s.pcr;
        e_ready = !m_held || e_prog;
`ifdef MCPU_ISSUE_STALL_CNT_EN
        e_stall = 64'(m_stall);
`else
        e_stall = 64'd0;
`endif
        obs_valid = ig.d2pc_valid;
        obs_prog  = ig.d2pc_progress;
        obs_ready = ig.ig2d_ready;
        obs_rd0   = ig.d2pc_out_rd_num0;
        obs_we0   = ig.d2pc_out_rd_we0;
        check("d2pc_valid", 64'(ig.d2pc_valid), 64'(e_valid));
        check("d2pc_progress", 64'(ig.d2pc_progress), 64'(e_prog));
        check("ig2d_ready", 64'(ig.ig2d_ready), 64'(e_ready));
        check("stall_cycles", 64'(ig.ig_stall_cycles), e_stall);
        if (m_held)
            check("out_fields",
                  64'({ig.d2pc_out_rd_num3, ig.d2pc_out_rd_num2, ig.d2pc_out_rd_num1, ig.d2pc_out_rd_num0,
                       ig.d2pc_out_rd_we3, ig.d2pc_out_rd_we2, ig.d2pc_out_rd_we1, ig.d2pc_out_rd_we0,
                       ig.d2pc_out_pred_we3, ig.d2pc_out_pred_we2, ig.d2pc_out_pred_we1, ig.d2pc_out_pred_we0}),
                  64'(model_outs(m_b)));
        if (haz && m_stall < 65535) m_stall++;
        if (s.fl) m_held = 0;
        else if (s.valid && e_ready) begin
            m_held = 1;
            m_b    = s;
        end else if (e_prog) m_held = 0;
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs[12];
    in_t         a, b, c;
    int          a_issue, b_issue, wb_left;
    logic [63:0] r64;
    logic [31:0] r32;

    initial begin
        total = 0;
        bad   = 0;
        m_held  = 0;
        m_b     = '0;
        m_stall = 0;
        a = blank();
        ig.flush = 0; ig.d2ig_valid = 0; ig.d2ig_rs_num = '0; ig.d2ig_rs_use = '0;
        ig.d2ig_pred_num = '0; ig.d2ig_rd_num = '0; ig.d2ig_rd_we = '0; ig.d2ig_pred_we = '0;
        ig.sb2d_reg_scoreboard = '0; ig.sb2d_pred_scoreboard = '0; ig.pc2d_ready = 0;

        // Reset state
        rst = 1'b0;
        #1 rst = 1'b1;
        #7;
        check("rst_ready", 64'(ig.ig2d_ready), 64'd1);
        check("rst_valid", 64'(ig.d2pc_valid), 64'd0);
        check("rst_progress", 64'(ig.d2pc_progress), 64'd0);
        check("rst_stall", 64'(ig.ig_stall_cycles), 64'd0);
        check("rst_outs", 64'({ig.d2pc_out_rd_num0, ig.d2pc_out_rd_num3, ig.d2pc_out_rd_we0,
                               ig.d2pc_out_pred_we3}), 64'd0);
        #4 rst = 1'b0;
        @(posedge clk);
        #1;

        // Source r5 busy for three cycles, then issue
        a = blank(); a.valid = 1; a.uses[0] = 1; a.rs[4:0] = 5'd5; a.pcr = 1;
        step(a);
        b = a; b.valid = 0; b.rsb = 32'd1 << 5;
        for (int k = 0; k < 3; k++) begin
            step(b);
            check("r5_stall_prog", 64'(obs_prog), 64'd0);
        end
        b.rsb = '0;
        step(b);
        check("r5_issue_prog", 64'(obs_prog), 64'd1);
        step(blank());
`ifdef MCPU_ISSUE_STALL_CNT_EN
        check("r5_stall_count", 64'(ig.ig_stall_cycles), 64'd3);
`else
        check("r5_stall_count", 64'(ig.ig_stall_cycles), 64'd0);
`endif

        // Directed vector table: load, apply conditions, drop
        for (int i = 0; i < 12; i++) begin
            vecs[i].st = blank(); vecs[i].st.pcr = 1;
        end
        vecs[0].st.uses[3] = 1; vecs[0].st.rs[15 +: 5] = 5'd12; vecs[0].st.rsb = 32'd1 << 12;
        vecs[0].ev = 0; vecs[0].ep = 0;
        vecs[1].st.uses[3] = 1; vecs[1].st.rs[15 +: 5] = 5'd12; vecs[1].st.rsb = 32'd1 << 13;
        vecs[1].ev = 1; vecs[1].ep = 1;
        vecs[2].st.rs[15 +: 5] = 5'd12; vecs[2].st.rsb = 32'd1 << 12; vecs[2].st.pcr = 0;
        vecs[2].ev = 1; vecs[2].ep = 0;
        vecs[3].st.pr = 8'hDF; vecs[3].st.psb = 3'b010;
        vecs[3].ev = 0; vecs[3].ep = 0;
        vecs[4].st.psb = 3'b010;
        vecs[4].ev = 1; vecs[4].ep = 1;
        vecs[5].st.rd[15 +: 5] = 5'd20; vecs[5].st.rwe = 4'b1000; vecs[5].st.rsb = 32'd1 << 20;
        vecs[5].ev = 0; vecs[5].ep = 0;
        vecs[6].st.rd[5 +: 5] = 5'd2; vecs[6].st.pwe = 4'b0010; vecs[6].st.psb = 3'b100;
        vecs[6].ev = 0; vecs[6].ep = 0;
        vecs[7].st.rd[5 +: 5] = 5'd3; vecs[7].st.pwe = 4'b0010; vecs[7].st.psb = 3'b111;
        vecs[7].ev = 1; vecs[7].ep = 1;
        vecs[8].st.rd[15 +: 5] = 5'd20; vecs[8].st.rsb = 32'd1 << 20;
        vecs[8].ev = 1; vecs[8].ep = 1;
        vecs[9].st.fl = 1;
        vecs[9].ev = 0; vecs[9].ep = 0;
        vecs[10].st.pr = 8'hFC; vecs[10].st.psb = 3'b001;
        vecs[10].ev = 0; vecs[10].ep = 0;
        vecs[11].st.uses[0] = 1; vecs[11].st.rsb = 32'd1;
        vecs[11].ev = 0; vecs[11].ep = 0;
        for (int i = 0; i < 12; i++) begin
            a = vecs[i].st; a.valid = 1; a.rsb = '0; a.psb = '0; a.pcr = 0; a.fl = 0;
            step(a);
            b = vecs[i].st; b.valid = 0;
            step(b);
            check($sformatf("vec%0d_valid", i), 64'(obs_valid), 64'(vecs[i].ev));
            check($sformatf("vec%0d_prog", i), 64'(obs_prog), 64'(vecs[i].ep));
            c = blank(); c.fl = 1;
            step(c);
        end

        // A writes r7, B reads r7 back-to-back with a scoreboard in the loop
        a = blank(); a.valid = 1; a.rd[4:0] = 5'd7; a.rwe = 4'b0001; a.pcr = 1;
        b = blank(); b.valid = 1; b.uses[0] = 1; b.rs[4:0] = 5'd7; b.pcr = 1;
        a_issue = -1; b_issue = -1; wb_left = 0;
        for (int k = 0; k < 12; k++) begin
            c = (k == 0) ? a : (k == 1) ? b : blank();
            c.pcr = 1;
            c.rsb = (wb_left > 0) ? (32'd1 << 7) : 32'd0;
            step(c);
            if (obs_prog && a_issue < 0) a_issue = k;
            else if (obs_prog && b_issue < 0) b_issue = k;
            if (wb_left > 0) wb_left--;
            if (obs_prog && obs_we0 && obs_rd0 == 5'd7) wb_left = 3;
        end
        check("raw_a_issue", 64'(a_issue), 64'd1);
        check("raw_b_gap", 64'(b_issue - a_issue), 64'd4);

        // Flush while stalled by downstream
        a = blank(); a.valid = 1; a.rd[4:0] = 5'd9;
        step(a);
        b = blank();
        step(b);
        check("fl_prehold_valid", 64'(obs_valid), 64'd1);
        check("fl_prehold_prog", 64'(obs_prog), 64'd0);
        c = blank(); c.fl = 1; c.valid = 1; c.rd[4:0] = 5'd11;
        step(c);
        check("fl_prog", 64'(obs_prog), 64'd0);
        check("fl_valid", 64'(obs_valid), 64'd0);
        b = blank(); b.pcr = 1;
        step(b);
        check("fl_after_valid", 64'(obs_valid), 64'd0);
        check("fl_after_ready", 64'(obs_ready), 64'd1);

        // Hazard-free stream: one issue per cycle
        for (int k = 0; k < 9; k++) begin
            a = blank(); a.pcr = 1; a.valid = (k < 8); a.rd[4:0] = 5'(10 + k);
            step(a);
            if (k >= 1) begin
                check("stream_prog", 64'(obs_prog), 64'd1);
                check("stream_ready", 64'(obs_ready), 64'd1);
                check("stream_rd0", 64'(obs_rd0), 64'(10 + k - 1));
            end
        end

        // Randomized stimulus against the model
        for (int k = 0; k < 400; k++) begin
            a = '0;
            r64 = {$urandom(), $urandom()};
            a.rs = r64[39:0];
            r32 = $urandom() & $urandom();
            a.uses = r32[7:0];
            r32 = $urandom();
            a.pr  = r32[7:0];
            a.rd  = r32[27:8];
            r32 = $urandom() & $urandom();
            a.rwe = r32[3:0];
            a.pwe = r32[7:4];
            a.rsb = $urandom() & $urandom() & $urandom();
            r32 = $urandom();
            a.psb = r32[2:0] & r32[5:3];
            a.valid = ($urandom_range(1, 0) == 1);
            a.pcr   = ($urandom_range(3, 0) != 0);
            a.fl    = ($urandom_range(15, 0) == 0);
            step(a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
